ex_dispatch_router: RTL and testbench

EX_DISPATCH_ROUTER -- requirements
Module: ex_dispatch_router

---
 rtl/ex_dispatch_router.sv | 149 ++++++++++++++
 tb/tb_ex_dispatch_router.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_dispatch_router.sv
// ex_dispatch_router: routes in-order issue lanes into per-functional-unit
// FIFOs and presents each FIFO head to its functional unit.
module ex_dispatch_router #(
   parameter int ISSUE_WIDTH = 2,
   parameter int FU_NUMBER   = 4,
   parameter int PAYLOAD_W   = 96,
   parameter int FIFO_DEPTH  = 2,
   localparam int FU_SEL_W   = (FU_NUMBER > 1) ? $clog2(FU_NUMBER) : 1,
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  flush,
   input  logic [ISSUE_WIDTH-1:0]                issue_valid,
   input  logic [ISSUE_WIDTH-1:0][FU_SEL_W-1:0]  issue_fu,
   input  logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0] issue_payload,
   output logic [ISSUE_WIDTH-1:0]                issue_ready,
   output logic [FU_NUMBER-1:0]                  fu_valid,
   output logic [FU_NUMBER-1:0][PAYLOAD_W-1:0]   fu_payload,
   input  logic [FU_NUMBER-1:0]                  fu_busy,
   output logic [FU_NUMBER-1:0][CNT_W-1:0]       fu_count,
   output logic                                  illegal_fu
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

   logic [FU_NUMBER-1:0][CNT_W-1:0]     count_q, count_d;
   logic [FU_NUMBER-1:0][PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [FU_NUMBER-1:0][PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PAYLOAD_W-1:0]                mem_q [FU_NUMBER][FIFO_DEPTH];
   logic [PAYLOAD_W-1:0]                mem_d [FU_NUMBER][FIFO_DEPTH];
   logic                                illegal_q, illegal_d;
   logic [FU_NUMBER-1:0]                push, pop;
   logic [FU_NUMBER-1:0][PAYLOAD_W-1:0] push_data;
   logic [ISSUE_WIDTH-1:0]              ready;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_C) ? '0 : p + 1'b1;
   endfunction

   // Lane acceptance: walk lanes in order, stop at the first valid lane that
   // cannot go, and let only the lowest lane claim each FU per cycle.
   always_comb begin
      logic                 in_order;
      logic                 lane_legal;
      logic                 lane_ok;
      logic [FU_NUMBER-1:0] claimed;
      ready      = '0;
      push       = '0;
      push_data  = '0;
      illegal_d  = 1'b0;
      claimed    = '0;
      lane_legal = 1'b0;
      lane_ok    = 1'b0;
      in_order   = rst_n & ~flush;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         lane_legal = 1'b0;
         lane_ok    = 1'b0;
         for (int k = 0; k < FU_NUMBER; k++) begin
            if (issue_fu[i] == FU_SEL_W'(k)) begin
               lane_legal = 1'b1;
               lane_ok    = (count_q[k] < DEPTH_C) && !claimed[k];
            end
         end
         if (!lane_legal) begin
            lane_ok = 1'b1;
         end
         ready[i] = in_order & lane_ok;
         if (issue_valid[i] && ready[i]) begin
            if (lane_legal) begin
               for (int k = 0; k < FU_NUMBER; k++) begin
                  if (issue_fu[i] == FU_SEL_W'(k)) begin
                     push[k]      = 1'b1;
                     push_data[k] = issue_payload[i];
                     claimed[k]   = 1'b1;
                  end
               end
            end else begin
               illegal_d = 1'b1;
            end
         end
         if (issue_valid[i] && !ready[i]) begin
            in_order = 1'b0;
         end
      end
   end

   // FIFO bookkeeping: write at the tail on push, advance the head on pop,
   // and let flush wipe every count and pointer.
   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      mem_d    = mem_q;
      pop      = '0;
      for (int k = 0; k < FU_NUMBER; k++) begin
         pop[k] = (count_q[k] != '0) && !fu_busy[k] && !flush;
         if (push[k]) begin
            mem_d[k][wr_ptr_q[k]] = push_data[k];
            wr_ptr_d[k]           = next_ptr(wr_ptr_q[k]);
         end
         if (pop[k]) begin
            rd_ptr_d[k] = next_ptr(rd_ptr_q[k]);
         end
         count_d[k] = count_q[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
      end
      if (flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end
   end

   // Valid-bearing state: counts, pointers and the illegal-index pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         illegal_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         illegal_q <= illegal_d;
      end
   end

   // Payload storage carries no valid meaning of its own, so it is not reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Outputs: heads come straight from storage, validity from the counts.
   always_comb begin
      issue_ready = ready;
      fu_count    = count_q;
      illegal_fu  = illegal_q;
      fu_valid    = '0;
      fu_payload  = '0;
      for (int k = 0; k < FU_NUMBER; k++) begin
         fu_valid[k]   = (count_q[k] != '0);
         fu_payload[k] = mem_q[k][rd_ptr_q[k]];
      end
   end

endmodule

// File: tb/tb_ex_dispatch_router.sv
// tb_ex_dispatch_router: table vectors, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_ex_dispatch_router;

   localparam int NFU   = 4;
   localparam int DEPTH = 2;

   logic                 clk;
   logic                 rst_n;
   logic                 flush;
   logic [1:0]           issue_valid;
   logic [1:0][1:0]      issue_fu;
   logic [1:0][95:0]     issue_payload;
   logic [1:0]           issue_ready;
   logic [3:0]           fu_valid;
   logic [3:0][95:0]     fu_payload;
   logic [3:0]           fu_busy;
   logic [3:0][1:0]      fu_count;
   logic                 illegal_fu;

   // second instance with three FUs so that index 3 is out of range
   logic                 flush3;
   logic [1:0]           valid3;
   logic [1:0][1:0]      fu3;
   logic [1:0][95:0]     payload3;
   logic [1:0]           ready3;
   logic [2:0]           fvalid3;
   logic [2:0][95:0]     fpayload3;
   logic [2:0]           busy3;
   logic [2:0][1:0]      count3;
   logic                 illegal3;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: one payload queue per FU
   logic [95:0] mq [NFU][$];
   logic        ill_exp;
   logic [1:0]  exp_ready;

   typedef struct {
      logic [1:0] valid;
      logic [1:0] fu0;
      logic [1:0] fu1;
      logic       flush;
      logic [1:0] exp_ready;
      logic [3:0] exp_fvalid;
   } vec_t;
   vec_t vecs[6];

   ex_dispatch_router dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_payload(issue_payload),
      .issue_ready(issue_ready), .fu_valid(fu_valid), .fu_payload(fu_payload),
      .fu_busy(fu_busy), .fu_count(fu_count), .illegal_fu(illegal_fu)
   );

   ex_dispatch_router #(.FU_NUMBER(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .flush(flush3),
      .issue_valid(valid3), .issue_fu(fu3), .issue_payload(payload3),
      .issue_ready(ready3), .fu_valid(fvalid3), .fu_payload(fpayload3),
      .fu_busy(busy3), .fu_count(count3), .illegal_fu(illegal3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] f0, input logic [1:0] f1,
                                input logic [95:0] p0, input logic [95:0] p1);
      issue_valid      = valid;
      issue_fu[0]      = f0;
      issue_fu[1]      = f1;
      issue_payload[0] = p0;
      issue_payload[1] = p1;
   endtask

   // A lane may go when reset and flush are off, no earlier valid lane has
   // stalled, its FU has room, and no earlier valid lane targets that FU.
   function automatic logic [1:0] modelReady();
      logic [1:0] r;
      bit ok;
      bit dup;
      r  = '0;
      ok = rst_n && !flush;
      for (int i = 0; i < 2; i++) begin
         dup = 0;
         for (int j = 0; j < i; j++)
            if (issue_valid[j] && issue_fu[j] == issue_fu[i]) dup = 1;
         if (ok && mq[issue_fu[i]].size() < DEPTH && !dup) r[i] = 1'b1;
         if (issue_valid[i] && !r[i]) ok = 0;
      end
      return r;
   endfunction

   task automatic compareModel();
      exp_ready = modelReady();
      checkOutput("issue_ready", 128'(issue_ready), 128'(exp_ready));
      for (int k = 0; k < NFU; k++) begin
         checkOutput($sformatf("fu_count[%0d]", k), 128'(fu_count[k]), 128'(mq[k].size()));
         checkOutput($sformatf("fu_valid[%0d]", k), 128'(fu_valid[k]), 128'(mq[k].size() != 0));
         if (mq[k].size() != 0)
            checkOutput($sformatf("fu_payload[%0d]", k), 128'(fu_payload[k]), 128'(mq[k][0]));
      end
      checkOutput("illegal_fu", 128'(illegal_fu), 128'(ill_exp));
   endtask

   task automatic updateModel();
      if (!rst_n || flush) begin
         for (int k = 0; k < NFU; k++) mq[k].delete();
         ill_exp = 1'b0;
      end else begin
         for (int k = 0; k < NFU; k++)
            if (mq[k].size() != 0 && !fu_busy[k]) void'(mq[k].pop_front());
         for (int i = 0; i < 2; i++)
            if (issue_valid[i] && exp_ready[i]) mq[issue_fu[i]].push_back(issue_payload[i]);
         ill_exp = 1'b0;
      end
   endtask

   // one clock: compare just after inputs settle, then advance the model
   task automatic step();
      #1;
      compareModel();
      @(posedge clk);
      updateModel();
      @(negedge clk);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      flush = 1'b0;
      applyStimulus(2'b00, 2'd0, 2'd0, '0, '0);
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [95:0] pa;
      logic [95:0] pb;
      rst_n = 1'b0;
      flush = 1'b0;
      fu_busy = 4'b1111;
      applyStimulus(2'b00, 2'd0, 2'd0, '0, '0);
      flush3 = 1'b0;
      valid3 = 2'b00;
      fu3 = '0;
      payload3 = '0;
      busy3 = 3'b000;
      ill_exp = 1'b0;
      exp_ready = '0;
      vecs[0] = '{2'b11, 2'd2, 2'd3, 1'b0, 2'b11, 4'b1100};
      vecs[1] = '{2'b11, 2'd2, 2'd2, 1'b0, 2'b01, 4'b0100};
      vecs[2] = '{2'b01, 2'd1, 2'd0, 1'b0, 2'b11, 4'b0010};
      vecs[3] = '{2'b11, 2'd0, 2'd1, 1'b1, 2'b00, 4'b0000};
      vecs[4] = '{2'b10, 2'd0, 2'd3, 1'b0, 2'b11, 4'b1000};
      vecs[5] = '{2'b00, 2'd1, 2'd2, 1'b0, 2'b11, 4'b0000};

      @(negedge clk);
      $display("[TB] reset state");
      step();
      rst_n = 1'b1;

      $display("[TB] table vectors");
      for (int v = 0; v < 6; v++) begin
         doReset();
         fu_busy = 4'b1111;
         flush = vecs[v].flush;
         applyStimulus(vecs[v].valid, vecs[v].fu0, vecs[v].fu1, 96'(v + 16), 96'(v + 32));
         #1;
         checkOutput($sformatf("vec%0d ready", v), 128'(issue_ready), 128'(vecs[v].exp_ready));
         step();
         flush = 1'b0;
         applyStimulus(2'b00, 2'd0, 2'd0, '0, '0);
         #1;
         checkOutput($sformatf("vec%0d fu_valid", v), 128'(fu_valid), 128'(vecs[v].exp_fvalid));
      end

      $display("[TB] same-FU lanes keep order");
      doReset();
      fu_busy = 4'b1111;
      pa = 96'hAAAA_0000_1111;
      pb = 96'hBBBB_0000_2222;
      applyStimulus(2'b11, 2'd2, 2'd2, pa, pb);
      #1; checkOutput("samefu ready", 128'(issue_ready), 128'(2'b01));
      step();
      applyStimulus(2'b10, 2'd2, 2'd2, '0, pb);
      #1; checkOutput("samefu lane1 ready", 128'(issue_ready[1]), 128'(1'b1));
      step();
      applyStimulus(2'b00, 2'd0, 2'd0, '0, '0);
      fu_busy = 4'b1011;
      #1; checkOutput("samefu head A", 128'(fu_payload[2]), 128'(pa));
      step();
      #1; checkOutput("samefu head B", 128'(fu_payload[2]), 128'(pb));
      step();

      $display("[TB] full FIFO stall and release");
      doReset();
      fu_busy = 4'b0001;
      applyStimulus(2'b01, 2'd0, 2'd0, 96'h11, 96'h0);
      step();
      applyStimulus(2'b01, 2'd0, 2'd0, 96'h22, 96'h0);
      step();
      applyStimulus(2'b01, 2'd0, 2'd0, 96'h33, 96'h0);
      #1;
      checkOutput("full ready", 128'(issue_ready[0]), 128'(1'b0));
      checkOutput("full count", 128'(fu_count[0]), 128'(2'd2));
      step();
      fu_busy = 4'b0000;
      step();
      #1; checkOutput("release ready", 128'(issue_ready[0]), 128'(1'b1));
      step();

      $display("[TB] blocked lane keeps order");
      doReset();
      fu_busy = 4'b0010;
      applyStimulus(2'b01, 2'd1, 2'd0, 96'h44, 96'h0);
      step();
      step();
      applyStimulus(2'b11, 2'd1, 2'd2, 96'h55, 96'h66);
      #1; checkOutput("order ready", 128'(issue_ready), 128'(2'b00));
      step();

      $display("[TB] flush");
      doReset();
      fu_busy = 4'b1111;
      applyStimulus(2'b01, 2'd2, 2'd0, 96'h77, 96'h0);
      step();
      step();
      flush = 1'b1;
      #1; checkOutput("flush ready", 128'(issue_ready), 128'(2'b00));
      step();
      flush = 1'b0;
      applyStimulus(2'b00, 2'd0, 2'd0, '0, '0);
      #1;
      checkOutput("flush count2", 128'(fu_count[2]), 128'(2'd0));
      checkOutput("flush fu_valid", 128'(fu_valid), 128'(4'b0000));
      step();

      $display("[TB] out-of-range FU index");
      doReset();
      valid3 = 2'b01;
      fu3[0] = 2'd3;
      fu3[1] = 2'd0;
      payload3[0] = 96'h99;
      #1; checkOutput("illegal ready", 128'(ready3[0]), 128'(1'b1));
      step();
      valid3 = 2'b00;
      #1;
      checkOutput("illegal pulse", 128'(illegal3), 128'(1'b1));
      checkOutput("illegal counts", 128'(count3), 128'(0));
      checkOutput("illegal fu_valid", 128'(fvalid3), 128'(3'b000));
      step();
      #1; checkOutput("illegal pulse end", 128'(illegal3), 128'(1'b0));
      step();

      $display("[TB] random traffic");
      doReset();
      for (int c = 0; c < 400; c++) begin
         rst_n   = ($urandom_range(0, 49) != 0);
         flush   = ($urandom_range(0, 19) == 0);
         fu_busy = 4'($urandom & $urandom);
         applyStimulus(2'($urandom), 2'($urandom), 2'($urandom),
                       {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
